alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; shift amount for SHL/SHR.
REQ-008 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 MUL, 9-15 reserved.
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH  result, low half of product for MUL.
REQ-012 result_hi  output  WIDTH  high half of product for MUL, 0 for all other ops.
REQ-013 carry, ovf, zero, neg  output  1 each  status flags.
REQ-014 err  output  1  completed op was a reserved opcode.

Function
REQ-015 Accept occurs on a rising edge with in_valid=1 and in_ready=1; a, b, op are sampled only then.
REQ-016 FSM states: IDLE, MUL, DONE; IDLE->DONE on accept of non-MUL op; IDLE->MUL on accept of MUL; MUL->DONE after exactly WIDTH edges in MUL; DONE->IDLE on out_ready=1 with no new accept; DONE->DONE/MUL on out_ready=1 with simultaneous accept.
REQ-017 in_ready = 1 in IDLE, = out_ready in DONE, = 0 in MUL and while rst_n=0.
REQ-018 out_valid = 1 exactly in state DONE; non-MUL latency: out_valid high in the cycle after the accepting edge.
REQ-019 MUL latency: out_valid rises WIDTH+1 edges after the accepting edge; iterative shift-add, one multiplier bit per edge, unsigned.
REQ-020 result, result_hi, flags and err hold stable while out_valid=1 and out_ready=0.
REQ-021 ADD: {carry,result} = a+b unsigned; ovf = signed two's-complement overflow.
REQ-022 SUB: result = a-b mod 2^WIDTH; carry = 1 when a<b unsigned (borrow); ovf = signed overflow.
REQ-023 AND/OR/XOR bitwise on a,b; NOT = ~a; carry=0, ovf=0.
REQ-024 SHL/SHR logical, zero-fill, amount = unsigned b; b >= WIDTH gives result 0; carry=0, ovf=0.
REQ-025 MUL: {result_hi,result} = a*b (2*WIDTH bits); carry = |result_hi; ovf=0.
REQ-026 zero = (result==0) for all ops, and (result_hi==0 && result==0) for MUL; neg = result[WIDTH-1].
REQ-027 Reserved op: result=0, result_hi=0, carry=ovf=neg=0, zero=1, err=1, single-cycle latency; err=0 for all legal ops.
REQ-028 in_valid while in_ready=0 is ignored, not queued; requester holds it.

Reset
REQ-029 rst_n=0 forces immediately, independent of clk: state IDLE, out_valid=0, result=0, result_hi=0, carry=ovf=neg=err=0, zero=0, in_ready=0.
REQ-030 Reset during MUL or DONE aborts the operation; no result is delivered for it; first accept possible on the first edge after rst_n rises.

Verification (WIDTH=8)
REQ-031 ADD a=0xF0 b=0x20 -> result 0x10, carry 1, ovf 0, zero 0, out_valid next cycle.
REQ-032 SUB a=0x05 b=0x07 -> result 0xFE, carry 1, neg 1; SUB a=0x80 b=0x01 -> result 0x7F, ovf 1, carry 0.
REQ-033 MUL a=0xFF b=0xFF -> result 0x01, result_hi 0xFE, carry 1, out_valid rises exactly 9 edges after accept, in_ready 0 throughout MUL.
REQ-034 SHL a=0x81 b=0x01 -> 0x02; SHR a=0x81 b=0x08 -> 0x00, zero 1; op=0xC -> err 1, result 0.
REQ-035 Backpressure: ADD completes, out_ready held 0 for 3 cycles -> outputs stable, in_ready 0; out_ready=1 with in_valid=1 (XOR 0xAA,0xFF) -> result 0x55 on next cycle, no bubble.
REQ-036 Reset asserted mid-MUL (4th cycle) -> out_valid 0 and outputs 0 immediately; after release, ADD 0x01+0x01 -> 0x02 with single-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith ops, iterative shift-add unsigned multiply.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;
  logic             w_shift_oob;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_step;

  assign in_ready  = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);

  // Single-cycle datapath for every non-multiply opcode
  assign w_sum       = {1'b0, a} + {1'b0, b};
  assign w_diff      = {1'b0, a} - {1'b0, b};
  assign w_shift_oob = 32'(b) >= WIDTH;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: w_res = w_shift_oob ? '0 : (a << b);
      OP_SHR: w_res = w_shift_oob ? '0 : (a >> b);
      OP_MUL: w_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  // One multiplier bit per cycle: conditionally add, then shift {hi,lo} right
  assign w_addend = r_lo[0] ? r_mcand : '0;
  assign w_step   = {1'b0, r_hi} + {1'b0, w_addend};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else if (w_accept) begin
      if (op == OP_MUL) begin
        r_state <= S_MUL;
        r_mcand <= a;
        r_hi    <= '0;
        r_lo    <= b;
        r_cnt   <= '0;
      end else begin
        r_state   <= S_DONE;
        result    <= w_res;
        result_hi <= '0;
        carry     <= w_carry;
        ovf       <= w_ovf;
        zero      <= ~|w_res;
        neg       <= w_res[WIDTH-1];
        err       <= w_err;
      end
    end else begin
      case (r_state)
        S_MUL: begin
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_state   <= S_DONE;
            result    <= r_lo;
            result_hi <= r_hi;
            carry     <= |r_hi;
            ovf       <= 1'b0;
            zero      <= ~|{r_hi, r_lo};
            neg       <= r_lo[WIDTH-1];
            err       <= 1'b0;
          end else begin
            r_hi  <= w_step[WIDTH:1];
            r_lo  <= {w_step[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed corner cases plus
// randomized traffic against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    logic         e;
    logic [3:0]   op;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry, ovf, zero, neg, err;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_bp = 1'b0;
  exp_t q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry), .ovf(ovf),
    .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode definitions
  function automatic exp_t model(input logic [3:0] mop, input int unsigned oa, input int unsigned ob);
    exp_t        e;
    int          sa, sb, s;
    int unsigned m;
    longint unsigned p;
    m  = 1 << W;
    sa = (oa >= m / 2) ? int'(oa) - int'(m) : int'(oa);
    sb = (ob >= m / 2) ? int'(ob) - int'(m) : int'(ob);
    e  = '0;
    e.op = mop;
    p  = 0;
    case (mop)
      4'd0: begin
        e.r = W'((oa + ob) % m);
        e.c = (oa + ob) >= m;
        s   = sa + sb;
        e.v = (s > int'(m / 2) - 1) || (s < -int'(m / 2));
      end
      4'd1: begin
        e.r = W'((oa + m - ob) % m);
        e.c = oa < ob;
        s   = sa - sb;
        e.v = (s > int'(m / 2) - 1) || (s < -int'(m / 2));
      end
      4'd2: e.r = W'(oa & ob);
      4'd3: e.r = W'(oa | ob);
      4'd4: e.r = W'(oa ^ ob);
      4'd5: e.r = W'(m - 1 - oa);
      4'd6: e.r = (ob >= W) ? '0 : W'((oa * (1 << ob)) % m);
      4'd7: e.r = (ob >= W) ? '0 : W'(oa / (1 << ob));
      4'd8: begin
        p    = longint'(oa) * longint'(ob);
        e.r  = W'(p % m);
        e.hi = W'(p / m);
        e.c  = (p / m) != 0;
      end
      default: e.e = 1'b1;
    endcase
    e.z = (mop == 4'd8) ? (p == 0) : (e.r == 0);
    e.n = e.r[W-1];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Present a request and hold it until accepted; returns 1 ns after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = xa;
    b = xb;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    if (ok) q.push_back(model(o, int'(xa), int'(xb)));
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: op %0d never accepted", o);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake pops and checks one expected result
  always @(negedge clk) begin
    exp_t e, got;
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
      end else begin
        e   = q.pop_front();
        got = {result, result_hi, carry, ovf, zero, neg, err, e.op};
        if (got !== e) begin
          n_err++;
          $display("FAIL result op%0d: got r=%h hi=%h c%b v%b z%b n%b e%b expected r=%h hi=%h c%b v%b z%b n%b e%b",
                   e.op, got.r, got.hi, got.c, got.v, got.z, got.n, got.e,
                   e.r, e.hi, e.c, e.v, e.z, e.n, e.e);
        end
      end
    end
  end

  // Random consumer backpressure, changed just after each rising edge
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen_ready;
    logic [20:0] snap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_result", 32'({result_hi, result}), 0);
    chk("rst_flags", 32'({carry, ovf, zero, neg, err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);

    issue(4'd0, 8'hF0, 8'h20);
    chk("add_latency", 32'(out_valid), 1);
    issue(4'd1, 8'h05, 8'h07);
    issue(4'd1, 8'h80, 8'h01);

    // Multiply latency and in_ready during iteration
    issue(4'd8, 8'hFF, 8'hFF);
    n = 0;
    seen_ready = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) seen_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'(W + 1));
    chk("mul_in_ready_low", 32'(seen_ready), 0);

    issue(4'd6, 8'h81, 8'h01);
    issue(4'd7, 8'h81, 8'h08);
    issue(4'hC, 8'h12, 8'h34);
    chk("reserved_latency", 32'(out_valid), 1);

    // Backpressure: result holds, then back-to-back accept with no bubble
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(4'd0, 8'h7F, 8'h01);
    snap = {result, result_hi, carry, ovf, zero, neg, err};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", 32'({result, result_hi, carry, ovf, zero, neg, err}), 32'(snap));
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    issue(4'd4, 8'hAA, 8'hFF);
    chk("no_bubble", 32'(out_valid), 1);

    // Reset in the 4th multiply cycle aborts it
    issue(4'd8, 8'h37, 8'h5A);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_outputs", 32'({result, result_hi, carry, ovf, zero, neg, err}), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    issue(4'd0, 8'h01, 8'h01);
    chk("post_reset_latency", 32'(out_valid), 1);

    // Randomized traffic with random consumer stalls
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ro = 4'($urandom_range(0, 11));
      ra = W'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
      issue(ro, ra, rb);
    end

    // Drain
    @(posedge clk);
    rand_bp = 1'b0;
    #2;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(q.size()), 0);
    chk("drain_idle", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
